// File: rtl/sample_extract_pkg.sv
// Shared types for the sample-extraction block. The ring geometry comes from the
// shared defines; the fallbacks below only apply when those were not read first.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 9
`endif
`ifndef RING_SIZE
`define RING_SIZE 512
`endif
`ifndef MODULUS
`define MODULUS 12289
`endif

package sample_extract_pkg;
  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } se_state_t;
endpackage

// File: rtl/sample_extract_if.sv
// Accumulator read port plus output stream handshake of the sample extractor.
interface sample_extract_if #(
  parameter int unsigned DATA_W = `DATA_SIZE_ARB,
  parameter int unsigned RING_D = `RING_DEPTH
);
  logic              start;
  logic [RING_D:0]   acc_raddr;
  logic [DATA_W-1:0] acc_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, acc_rdata, out_ready,
    output acc_raddr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, acc_rdata, out_ready,
    input  acc_raddr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/sample_extract_skid.sv
// Two-entry FIFO between the accumulator read pipe and the output handshake.
module sample_extract_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);
  logic [W-1:0] ent [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign pop_data = ent[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent[0] <= '0;
      ent[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sample_extract.sv
// Streams a[0], -a[N-1..1] mod Q and b[0] out of the accumulator memory,
// throttling reads so the 2-entry skid buffer can never overflow.
module sample_extract
  import sample_extract_pkg::*;
#(
  parameter int unsigned DATA_W = `DATA_SIZE_ARB,
  parameter int unsigned RING_D = `RING_DEPTH,
  parameter int unsigned MOD_Q  = `MODULUS
) (
  input logic              clk,
  input logic              reset,
  sample_extract_if.master bus
);
  // state   | meaning
  // S_IDLE  | waiting for start
  // S_READ  | issuing the N+1 accumulator reads
  // S_DRAIN | all reads issued, emptying the skid buffer

  localparam int unsigned    AW    = RING_D + 1;
  localparam logic [AW-1:0]  N_IDX = AW'(1) << RING_D;

  se_state_t         state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     raddr_q;
  logic [AW-1:0]     next_addr;
  logic              rd_pend;
  logic              neg_q;
  logic              last_q;
  logic              issue;
  logic              room;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W:0]   head;

  // A pop in the same cycle frees a slot, which keeps the stream bubble-free.
  assign pop       = bus.out_valid && bus.out_ready;
  assign room      = ({1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop}) < 3'(SKID_DEPTH);
  assign issue     = (state == S_READ) && room;
  assign next_addr = (idx == '0 || idx == N_IDX) ? idx : N_IDX - idx;
  assign bus.acc_raddr = issue ? next_addr : raddr_q;

  assign rd_val = (neg_q && bus.acc_rdata != '0) ? DATA_W'(MOD_Q) - bus.acc_rdata
                                                 : bus.acc_rdata;

  sample_extract_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend),
    .push_data ({last_q, rd_val}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_cnt)
  );

  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = head[DATA_W-1:0];
  assign bus.out_last  = bus.out_valid && head[DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      raddr_q  <= '0;
      rd_pend  <= 1'b0;
      neg_q    <= 1'b0;
      last_q   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      rd_pend  <= issue;
      bus.done <= 1'b0;
      if (issue) begin
        raddr_q <= next_addr;
        neg_q   <= (idx != '0) && (idx != N_IDX);
        last_q  <= (idx == N_IDX);
        idx     <= idx + AW'(1);
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_READ;
            bus.busy <= 1'b1;
            idx      <= '0;
          end
        end
        S_READ: begin
          if (issue && idx == N_IDX) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && bus.out_last) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            idx      <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_extract.sv
// Directed bench for sample_extract with a 1-cycle-latency accumulator memory model.
module tb_sample_extract;
  localparam int DW = 32;
  localparam int RD = 9;
  localparam int N  = 512;
  localparam int Q  = 12289;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] mem [2*N];
  logic [DW-1:0] got [N+1];

  sample_extract_if #(.DATA_W(DW), .RING_D(RD)) bus ();

  sample_extract #(.DATA_W(DW), .RING_D(RD), .MOD_Q(Q)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.acc_rdata <= mem[bus.acc_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int i);
    logic [DW-1:0] x;
    if (i == 0) return mem[0];
    if (i == N) return mem[N];
    x = mem[N-i];
    return (x == '0) ? '0 : DW'(Q) - x;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs from the negedge after start was sampled until done (or reset abort).
  task automatic collect(input string tag, input bit rnd, input int hold_low,
                         input int restart_at, input int reset_at,
                         output int first_v, output int cyc);
    int            word;
    bit            stalled;
    logic [DW-1:0] held_d;
    logic          held_l;
    bit            fin;
    bit            restarted;
    word = 0; stalled = 0; held_d = '0; held_l = 1'b0; fin = 0; restarted = 0;
    first_v = -1; cyc = 0;
    while (!fin && cyc < 20 * N) begin
      if (word > N) begin
        chk({tag, "_done"},  32'(bus.done), 32'd1);
        chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
        chk({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
        fin = 1;
      end else if (word == reset_at) begin
        reset = 1'b0;
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rst_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_rst_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_rst_done"},  32'(bus.done),      32'd0);
        chk({tag, "_rst_data"},  bus.out_data,       32'd0);
        chk({tag, "_rst_addr"},  32'(bus.acc_raddr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        fin = 1;
      end else begin
        if (first_v < 0 && bus.out_valid) first_v = cyc;
        if (stalled) begin
          chk($sformatf("%s_hold_v%0d", tag, word), 32'(bus.out_valid), 32'd1);
          chk($sformatf("%s_hold_d%0d", tag, word), bus.out_data, held_d);
          chk($sformatf("%s_hold_l%0d", tag, word), 32'(bus.out_last), 32'(held_l));
        end
        chk($sformatf("%s_busy%0d", tag, cyc), 32'(bus.busy), 32'd1);
        bus.out_ready = (cyc < hold_low) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        if (hold_low > 0 && cyc == hold_low - 1)
          chk({tag, "_two_reads"}, 32'(bus.acc_raddr), 32'(N - 1));
        if (bus.out_valid && bus.out_ready) begin
          got[word] = bus.out_data;
          chk($sformatf("%s_w%0d", tag, word), bus.out_data, exp_word(word));
          chk($sformatf("%s_last%0d", tag, word), 32'(bus.out_last), 32'(word == N));
          word++;
          stalled = 0;
        end else begin
          stalled = bus.out_valid;
          held_d  = bus.out_data;
          held_l  = bus.out_last;
        end
        bus.start = (word == restart_at) && !restarted;
        if (bus.start) restarted = 1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk({tag, "_timeout_words"}, 32'(word), 32'(N + 1));
  endtask

  initial begin
    int fv;
    int cy;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_last",  32'(bus.out_last),  32'd0);
    chk("reset_busy",  32'(bus.busy),      32'd0);
    chk("reset_done",  32'(bus.done),      32'd0);
    chk("reset_data",  bus.out_data,       32'd0);
    chk("reset_addr",  32'(bus.acc_raddr), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    mem[0] = 32'd5; mem[N-1] = 32'd0; mem[1] = 32'd7; mem[N] = 32'd123;
    start_pulse();
    collect("basic", 1'b0, 0, -1, -1, fv, cy);
    chk("basic_w0",    got[0],   32'd5);
    chk("basic_w1",    got[1],   32'd0);
    chk("basic_wN-1",  got[N-1], 32'(Q - 7));
    chk("basic_b",     got[N],   32'd123);
    chk("basic_cycles", 32'(cy), 32'(N + 3));
    @(negedge clk);
    chk("basic_done_pulse", 32'(bus.done), 32'd0);

    for (int k = 0; k < 2 * N; k++) mem[k] = DW'(k);
    start_pulse();
    collect("ramp", 1'b0, 0, -1, -1, fv, cy);
    chk("ramp_first_valid", 32'(fv), 32'd2);
    chk("ramp_cycles", 32'(cy), 32'(N + 3));
    chk("ramp_w0",   got[0],   32'd0);
    chk("ramp_w1",   got[1],   32'(Q - (N - 1)));
    chk("ramp_w100", got[100], 32'(Q - (N - 100)));
    chk("ramp_b",    got[N],   32'(N));

    start_pulse();
    collect("rand", 1'b1, 0, -1, -1, fv, cy);
    bus.out_ready = 1'b1;

    start_pulse();
    collect("restart", 1'b0, 0, 100, -1, fv, cy);
    chk("restart_cycles", 32'(cy), 32'(N + 3));

    start_pulse();
    collect("abort", 1'b0, 0, -1, 300, fv, cy);
    bus.out_ready = 1'b1;
    start_pulse();
    collect("fresh", 1'b0, 0, -1, -1, fv, cy);
    chk("fresh_first_valid", 32'(fv), 32'd2);
    chk("fresh_cycles", 32'(cy), 32'(N + 3));

    bus.out_ready = 1'b0;
    start_pulse();
    collect("hold", 1'b0, 20, -1, -1, fv, cy);
    chk("hold_w0", got[0], 32'd0);
    chk("hold_b",  got[N], 32'(N));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
